uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the CPU's serial transmit path on uart_tx_line.
- Deserialises the external serial line into bytes and presents them through a one-entry holding register with a valid/ready handshake.
- The CPU, or a future RX FIFO, consumes the bytes.
- Sits beside the CPU in the top level, one clock domain, LSB-first framing matching the transmitter.

---
 rtl/sync2.sv | 28 ++
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync2.sv
// sync2 -- two-flop synchroniser for an asynchronous input pin.
//   clk   : destination clock, rising edge
//   rst   : asynchronous active-high reset; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronised output, two clocks behind d
module sync2 #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with a one-entry holding register.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   uart_rx_line : asynchronous serial input, idle high, LSB first
//   rx_data      : received byte, stable while rx_valid=1
//   rx_valid     : holding register full
//   rx_ready     : consumer accepts (transfer when rx_valid & rx_ready)
//   frame_err    : one-cycle pulse when the stop bit is sampled low
//   overrun      : sticky; a byte completed while the holding register was full
module uart_rx #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          rxs;
  logic          done_ok, done_bad;

  sync2 #(.W(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx_line),
    .q   (rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    sh_n     = sh;
    done_ok  = 1'b0;
    done_bad = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        // Mid start bit: a high line here was a glitch, not a frame.
        if (cnt == HALF) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          sh_n  = {rxs, sh[7:1]};
          idx_n = idx + 1'b1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (cnt == LAST) begin
          cnt_n    = '0;
          state_n  = IDLE;
          done_ok  = rxs;
          done_bad = !rxs;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= done_bad;
      // A same-cycle accept frees the register in time for the new byte.
      if (done_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else begin
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
        if (done_ok) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx at CLKS_PER_BIT=16.
// A frame-level model predicts holding-register contents, rx_valid,
// overrun and frame_err every cycle; literal checks pin key results.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx_line (line),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  // Start edge to rx_valid: 2 + 16/2 + 9*16 + 1 clocks.
  localparam int LAT = 155;

  typedef struct {
    int         cyc;
    logic       stop;
    logic [7:0] data;
  } ev_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  ev_t  ev_q[$];
  ev_t  ev;
  logic [7:0] got_q[$];
  int   ferr_cnt = 0;

  logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, nv;
  logic [7:0] m_data = 8'h00;
  logic       prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // Model update and per-cycle compare, #1 after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0; m_ferr = 1'b0;
      ev_q.delete();
    end else begin
      nv     = m_valid && !rx_ready;
      m_ferr = 1'b0;
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        ev = ev_q.pop_front();
        if (!ev.stop)  m_ferr = 1'b1;
        else if (!nv) begin nv = 1'b1; m_data = ev.data; end
        else           m_ovr = 1'b1;
      end
      m_valid = nv;
    end
    chk("rx_valid",  {31'd0, rx_valid},  {31'd0, m_valid});
    chk("rx_data",   {24'd0, rx_data},   {24'd0, m_data});
    chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
    chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
    if (rx_valid && !prev_valid) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    prev_valid = rx_valid;
  end

  // One 8N1 frame, 16 clocks per bit, line changes on falling edges.
  task automatic send(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        if (j == 0) begin
          line = fr[i];
          if (i == 0) ev_q.push_back(ev_t'{cyc + LAT, stop, d});
        end
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int lat_cnt;
  int nfe;
  int ngot;

  initial begin
    rst = 1'b1; line = 1'b1; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset rx_valid",  {31'd0, rx_valid},  32'd0);
    chk("reset rx_data",   {24'd0, rx_data},   32'd0);
    chk("reset frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset overrun",   {31'd0, overrun},   32'd0);
    rst = 1'b0;
    idle(8);

    // Single byte with rx_ready low, latency measured from the start edge.
    lat_cnt = 0;
    fork
      send(8'hA5, 1'b1);
      begin
        while (lat_cnt < 300) begin
          @(posedge clk); #1;
          lat_cnt++;
          if (rx_valid) break;
        end
      end
    join
    checks++;
    if (lat_cnt < LAT - 2 || lat_cnt > LAT + 2) begin
      errors++;
      $display("FAIL latency: got %0d clocks expected %0d +-2", lat_cnt, LAT);
    end
    chk("a5 data",      {24'd0, rx_data},   32'h0000_00A5);
    chk("a5 valid",     {31'd0, rx_valid},  32'd1);
    chk("a5 frame_err", {31'd0, frame_err}, 32'd0);
    chk("a5 overrun",   {31'd0, overrun},   32'd0);
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    chk("a5 accepted", {31'd0, rx_valid}, 32'd0);
    idle(8);

    // Back-to-back frames, no idle gap, consumer always ready.
    rx_ready = 1'b1;
    got_q.delete();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h55, 1'b1);
    idle(8);
    chk("b2b count", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      chk("b2b byte0", {24'd0, got_q[0]}, 32'h00);
      chk("b2b byte1", {24'd0, got_q[1]}, 32'hFF);
      chk("b2b byte2", {24'd0, got_q[2]}, 32'h55);
    end
    chk("b2b no ferr", ferr_cnt, 32'd0);

    // Start glitch: 4 clocks low is rejected at mid start bit.
    got_q.delete();
    @(negedge clk); line = 1'b0;
    repeat (4) @(negedge clk);
    line = 1'b1;
    repeat (32) @(negedge clk);
    chk("glitch no byte", got_q.size(), 32'd0);
    chk("glitch no ferr", ferr_cnt, 32'd0);
    send(8'h3C, 1'b1);
    idle(8);
    chk("after glitch count", got_q.size(), 32'd1);
    chk("after glitch data", {24'd0, rx_data}, 32'h3C);

    // Bad stop bit, then a good frame.
    nfe = ferr_cnt; ngot = got_q.size();
    send(8'h81, 1'b0);
    idle(32);
    chk("bad stop ferr pulses", ferr_cnt - nfe, 32'd1);
    chk("bad stop no byte", got_q.size() - ngot, 32'd0);
    send(8'h42, 1'b1);
    idle(8);
    chk("after bad stop data", {24'd0, rx_data}, 32'h42);

    // Overrun: second byte arrives while first is still held.
    rx_ready = 1'b0;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    idle(8);
    chk("ovr data held", {24'd0, rx_data},  32'h11);
    chk("ovr valid",     {31'd0, rx_valid}, 32'd1);
    chk("ovr flag",      {31'd0, overrun},  32'd1);
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    chk("ovr accepted", {31'd0, rx_valid}, 32'd0);
    repeat (4) @(negedge clk);
    chk("ovr sticky", {31'd0, overrun}, 32'd1);

    // Reset during bit 3 of 0x99.
    fork
      send(8'h99, 1'b1);
      begin
        repeat (72) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async rst valid",   {31'd0, rx_valid},  32'd0);
        chk("async rst data",    {24'd0, rx_data},   32'd0);
        chk("async rst overrun", {31'd0, overrun},   32'd0);
        chk("async rst ferr",    {31'd0, frame_err}, 32'd0);
      end
    join
    @(negedge clk); rst = 1'b0;
    idle(8);
    rx_ready = 1'b1;
    send(8'h66, 1'b1);
    idle(8);
    chk("post rst data", {24'd0, rx_data}, 32'h66);
    chk("post rst overrun", {31'd0, overrun}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
